button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Conditions the raw push-button inputs before they reach the stacker game core. Each button is synchronised, debounced, edge-detected and auto-repeated on the fast system clock. The result is a sticky per-button event. Each event is held until the game's slow tick consumes it, so presses between ticks are never lost. The event bus drives the game's 3-bit buttons input directly.

Parameters:
NUM_BTN, 3, number of button channels.
DB_CYCLES, 250000, input must be stable this many clk cycles before the debounced level changes (5 ms at 50 MHz).
RPT_DELAY, 25000000, hold time in clk cycles from press before the first auto-repeat (0.5 s).
RPT_PERIOD, 10000000, clk cycles between subsequent auto-repeats (0.2 s).
RPT_EN, 3'b011, per-button auto-repeat enable mask (left/right repeat, rotate/drop does not).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
btn_raw  input  NUM_BTN  raw, bouncy, asynchronous button pins, active-high.
enable  input  1  game active (gamestate == PLAY); when low, events are neither set nor held.
consume  input  1  single-clk pulse from the game-tick domain, already in clk domain; clears all events.
btn_level  output  NUM_BTN  debounced button level.
btn_press  output  NUM_BTN  one-cycle pulse per press or auto-repeat.
btn_event  output  NUM_BTN  sticky event flags, to the game buttons input.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: synchroniser flops, btn_level, btn_press, btn_event, and all counters are 0.
- Synchroniser: two-flop synchroniser per channel; the second flop's output is s.
- Debounce:
  - Counter width is $clog2(DB_CYCLES+1).
  - The counter clears whenever s == btn_level.
  - Otherwise it increments. On the edge where it would reach DB_CYCLES, btn_level takes s and the counter clears.
  - Latency from a clean raw edge to btn_level change is DB_CYCLES+2 clk edges.
  - Any bounce that returns s to btn_level restarts the count.
- Press pulse:
  - btn_press[i] is registered.
  - It is high exactly in the first cycle btn_level[i] is 1, i.e. set on the same edge that raises btn_level.
  - There is no pulse on release.
- Auto-repeat:
  - Only channels with RPT_EN[i] = 1 auto-repeat.
  - A hold counter starts at 0 on the press edge and increments while btn_level[i] = 1.
  - The first repeat pulse occurs RPT_DELAY cycles after the press pulse. Further repeat pulses occur every RPT_PERIOD cycles after that.
  - Release (btn_level falling) clears the hold counter immediately, with no pulse in that cycle.
  - The hold counter saturates and never wraps to create a spurious pulse.
- Sticky event:
  - btn_event[i] sets on btn_press[i] & enable.
  - It clears on consume, or on the cycle enable is low.
  - If a set and consume occur in the same cycle, set wins: the new event survives for the next tick.
  - Multiple presses before a consume collapse into one event.
- Per-channel state machine: IDLE (level 0) -> PRESSED (level rose, wait RPT_DELAY) -> REPEAT (pulse every RPT_PERIOD). Any state returns to IDLE when level falls. On a channel with RPT_EN = 0, PRESSED holds until release.
- Channel independence: channels are fully independent, and simultaneous presses produce simultaneous pulses.
- Reset mid-operation: asynchronous clear of all state. A button held through reset is re-detected as a new press after DB_CYCLES+2 cycles.
- enable low: the debounce, level and press paths keep running. Only btn_event is gated.

Decomposition:
- Package button_pkg: constant names for channel indices (BTN_LEFT = 0, BTN_RIGHT = 1, BTN_ROT = 2) and the default timing constants.
- Sub-module btn_channel, one per button via generate. It contains the synchroniser, debounce counter, IDLE/PRESSED/REPEAT FSM, hold counter and press pulse.
- The top level holds only the sticky event register and enable/consume logic.

Test Plan (DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, RPT_EN=3'b011):
- Reset: assert rst mid-operation with btn_raw=3'b111 -> all outputs 0 asynchronously. After release, btn_level=3'b111 and one btn_press pulse occur 6 edges later.
- Bounce: btn_raw[0] toggles 1,0,1,0 at 2-cycle spacing, then stable at 1 -> no change while bouncing. btn_level[0] rises 6 edges after the last edge, with exactly one btn_press[0] pulse.
- Auto-repeat: hold btn_raw[1] for 60 cycles after debounce -> btn_press[1] pulses at t=0, 20, 28, 36, 44, 52. A 62-cycle hold on btn 2 -> a single pulse only.
- Sticky/consume: enable=1, press btn 0 -> btn_event=3'b001 until consume. A consume on the same cycle as a new btn_press[0] -> btn_event[0] stays 1.
- Coalescing: two press pulses on btn 0 before one consume -> btn_event[0] is cleared by that single consume and does not reassert.
- Enable gating: enable=0 during a press -> btn_level and btn_press toggle normally but btn_event stays 0. A pending event is cleared in the cycle enable drops.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button conditioning path.
package button_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ROT   = 2;

  localparam int NUM_BTN_DEF    = 3;
  localparam int DB_CYCLES_DEF  = 250000;
  localparam int RPT_DELAY_DEF  = 25000000;
  localparam int RPT_PERIOD_DEF = 10000000;
  localparam logic [2:0] RPT_EN_DEF = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: sync, debounce, press/auto-repeat FSM.
module btn_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF,
  parameter bit RPT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int RPT_MAX =
    (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int HOLD_W = $clog2(RPT_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DLY_LAST =
    HOLD_W'(RPT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PER_LAST =
    HOLD_W'(RPT_PERIOD - 1);

  logic s1;
  logic s;
  logic [DB_W-1:0] db_cnt;
  logic [HOLD_W-1:0] hold;
  btn_state_e state;

  logic settle;
  logic rise;
  logic fall;

  assign settle = (s != level) && (db_cnt == DB_LAST);
  assign rise = settle & s;
  assign fall = settle & ~s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      hold   <= '0;
      state  <= ST_IDLE;
    end else begin
      press <= 1'b0;
      if (s == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_PRESSED;
            press <= 1'b1;
            hold  <= '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state <= ST_IDLE;
            hold  <= '0;
          end else if (RPT_EN && hold == DLY_LAST) begin
            state <= ST_REPEAT;
            press <= 1'b1;
            hold  <= '0;
          end else if (hold != '1) begin
            hold <= hold + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            state <= ST_IDLE;
            hold  <= '0;
          end else if (hold == PER_LAST) begin
            press <= 1'b1;
            hold  <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          hold  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Per-button conditioning channels plus sticky events
// held until the game tick consumes them.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN    = NUM_BTN_DEF,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF,
  parameter logic [NUM_BTN-1:0] RPT_EN =
    NUM_BTN'(RPT_EN_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  input  logic               consume,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_event
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (RPT_EN[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // A new press beats a simultaneous consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_event <= '0;
    end else if (!enable) begin
      btn_event <= '0;
    end else begin
      btn_event <= btn_press
                 | (btn_event & ~{NUM_BTN{consume}});
    end
  end

endmodule
